// File: rtl/cdb_broadcaster_if.sv
// cdb_broadcaster_if: source result ports and CDB broadcast bus.
interface cdb_broadcaster_if #(
    parameter int N_SRC = 4,
    parameter int TAG_W = 6
);
    localparam int SW = N_SRC > 1 ? $clog2(N_SRC) : 1;
    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC*TAG_W-1:0] src_tag;
    logic [N_SRC*32-1:0]    src_data;
    logic [N_SRC-1:0]       src_ready;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [31:0]            cdb_data;
    logic [SW-1:0]          cdb_src;
    modport master (
        output src_valid, src_tag, src_data,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
    modport slave (
        input  src_valid, src_tag, src_data,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: per-source result FIFOs arbitrated round-robin onto a registered CDB.
module cdb_broadcaster #(
    parameter int N_SRC = 4,
    parameter int TAG_W = 6,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic flush,
    cdb_broadcaster_if.slave bus
);
    localparam int SW = N_SRC > 1 ? $clog2(N_SRC) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [TAG_W-1:0] tag_mem [N_SRC][DEPTH];
    logic [31:0]      data_mem [N_SRC][DEPTH];
    logic [CW-1:0]    count_q [N_SRC];
    logic [CW-1:0]    count_d [N_SRC];
    logic [PW-1:0]    rd_q [N_SRC];
    logic [PW-1:0]    rd_d [N_SRC];
    logic [PW-1:0]    wr_q [N_SRC];
    logic [PW-1:0]    wr_d [N_SRC];
    logic [SW-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [SW-1:0]    cdb_src_q, cdb_src_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [31:0]      cdb_data_q, cdb_data_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic [N_SRC-1:0] ready, push, pop, req;
    logic             gnt, fire;
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            ready[i] = count_q[i] < CW'(DEPTH);
            push[i]  = bus.src_valid[i] && ready[i];
            req[i]   = count_q[i] != '0;
        end
        gnt     = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!gnt && req[(int'(rr_ptr_q) + k) % N_SRC]) begin
                gnt     = 1'b1;
                gnt_idx = SW'((int'(rr_ptr_q) + k) % N_SRC);
            end
        end
        // a grant in the flush cycle is dropped so nothing survives the flush
        fire = gnt && !flush;
        for (int i = 0; i < N_SRC; i++) begin
            pop[i]     = fire && gnt_idx == SW'(i);
            count_d[i] = flush ? '0 : count_q[i] + CW'(push[i]) - CW'(pop[i]);
            wr_d[i]    = flush ? '0 : wr_q[i] + PW'(push[i]);
            rd_d[i]    = flush ? '0 : rd_q[i] + PW'(pop[i]);
        end
        rr_ptr_d    = fire ? (gnt_idx == SW'(N_SRC - 1) ? '0 : gnt_idx + SW'(1)) : rr_ptr_q;
        cdb_valid_d = fire;
        cdb_src_d   = fire ? gnt_idx : cdb_src_q;
        cdb_tag_d   = fire ? tag_mem[gnt_idx][rd_q[gnt_idx]] : cdb_tag_q;
        cdb_data_d  = fire ? data_mem[gnt_idx][rd_q[gnt_idx]] : cdb_data_q;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_q[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
                data_mem[i][wr_q[i]] <= bus.src_data[i*32 +: 32];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                count_q[i] <= '0;
                rd_q[i]    <= '0;
                wr_q[i]    <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end
    assign bus.src_ready = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: directed checks of the CDB broadcaster with hand-computed expectations.
module tb_cdb_broadcaster;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    cdb_broadcaster_if #(.N_SRC(4), .TAG_W(6)) bus ();
    cdb_broadcaster #(.N_SRC(4), .TAG_W(6), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        bus.src_valid = '0;
        #3;
        rst = 1'b0;
    endtask
    task automatic set_src(input int i, input logic [5:0] t, input logic [31:0] d);
        bus.src_tag[i*6 +: 6]   = t;
        bus.src_data[i*32 +: 32] = d;
    endtask
    initial begin
        int k;
        int seen;
        logic r1, v1;
        int exp_edge [3] = '{3, 7, 11};
        bus.src_valid = '0;
        bus.src_tag = '0;
        bus.src_data = '0;
        #1;
        check("rst_valid", bus.cdb_valid, 0);
        check("rst_ready", bus.src_ready, 4'hF);
        check("rst_tag", bus.cdb_tag, 0);
        check("rst_data", bus.cdb_data, 0);
        check("rst_src", bus.cdb_src, 0);
        #2;
        rst = 1'b0;
        tick;
        // single result on source 2
        set_src(2, 6'h15, 32'hDEADBEEF);
        bus.src_valid = 4'b0100;
        tick;
        bus.src_valid = '0;
        check("single_lat1", bus.cdb_valid, 0);
        tick;
        check("single_valid", bus.cdb_valid, 1);
        check("single_tag", bus.cdb_tag, 6'h15);
        check("single_data", bus.cdb_data, 32'hDEADBEEF);
        check("single_src", bus.cdb_src, 2);
        tick;
        check("single_once", bus.cdb_valid, 0);
        check("single_hold", bus.cdb_tag, 6'h15);
        // contention from rr_ptr=0
        do_reset;
        for (int i = 0; i < 4; i++) set_src(i, 6'(6'h10 + i), 32'hA0 + i);
        bus.src_valid = 4'hF;
        tick;
        bus.src_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("cont_valid", bus.cdb_valid, 1);
            check("cont_src", bus.cdb_src, i);
            check("cont_data", bus.cdb_data, 32'hA0 + i);
        end
        tick;
        check("cont_end", bus.cdb_valid, 0);
        // backpressure on source 1
        do_reset;
        for (int i = 0; i < 4; i++) set_src(i, 6'(6'h20 + i), 32'h200 + i);
        bus.src_valid = 4'b1101;
        k = 0;
        seen = 0;
        for (int e = 1; e <= 12; e++) begin
            bus.src_valid[1] = k < 3;
            set_src(1, 6'(6'h31 + k), 32'h300 + k);
            r1 = bus.src_ready[1];
            v1 = bus.src_valid[1];
            tick;
            if (r1 && v1) k++;
            if (e == 2) check("bp_full", bus.src_ready[1], 0);
            if (e == 3) check("bp_free", bus.src_ready[1], 1);
            if (e == 4) check("bp_held_taken", k, 3);
            if (bus.cdb_valid && bus.cdb_src == 2'd1) begin
                if (seen < 3) begin
                    check("bp_order", bus.cdb_tag, 6'h31 + seen);
                    check("bp_edge", e, exp_edge[seen]);
                end
                seen++;
            end
        end
        check("bp_count", seen, 3);
        // fairness between sources 0 and 3
        do_reset;
        bus.src_valid = 4'b1001;
        for (int e = 1; e <= 9; e++) begin
            tick;
            if (e >= 2) begin
                check("fair_valid", bus.cdb_valid, 1);
                check("fair_src", bus.cdb_src, (e % 2 == 0) ? 0 : 3);
            end
        end
        // flush with two entries queued in source 0
        do_reset;
        bus.src_valid = 4'b1001;
        tick;
        bus.src_valid = 4'b0001;
        tick;
        check("fl_src0", bus.cdb_src, 0);
        tick;
        check("fl_src3", bus.cdb_src, 3);
        check("fl_two", bus.src_ready, 4'b1110);
        flush = 1'b1;
        bus.src_valid = 4'b0010;
        #1;
        check("fl_inflight", bus.cdb_valid, 1);
        tick;
        flush = 1'b0;
        bus.src_valid = '0;
        check("fl_valid", bus.cdb_valid, 0);
        check("fl_ready", bus.src_ready, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("fl_quiet", bus.cdb_valid, 0);
        end
        // asynchronous reset with entries queued
        do_reset;
        bus.src_valid = 4'hF;
        tick;
        bus.src_valid = '0;
        tick;
        check("ar_pre", bus.cdb_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", bus.cdb_valid, 0);
        check("ar_ready", bus.src_ready, 4'hF);
        check("ar_data", bus.cdb_data, 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("ar_stale", bus.cdb_valid, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of execution-unit result sources.
REQ-002 SHALL have parameter TAG_W, default 6: width of the rd_token carried on the CDB.
REQ-003 SHALL have parameter DEPTH, default 2: per-source result buffer entries, power of two, at least 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all buffered, unbroadcast results.
REQ-007 SHALL have port src_valid, input, N_SRC: per-source result-present strobe.
REQ-008 SHALL have port src_tag, input, N_SRC*TAG_W: per-source destination token; source i occupies bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port src_data, input, N_SRC*32: per-source result; source i occupies bits [i*32 +: 32].
REQ-010 SHALL have port src_ready, output, N_SRC: per-source buffer-can-accept indication.
REQ-011 SHALL have port cdb_valid, output, 1: a broadcast is present this cycle.
REQ-012 SHALL have port cdb_tag, output, TAG_W: token being broadcast.
REQ-013 SHALL have port cdb_data, output, 32: result being broadcast.
REQ-014 SHALL have port cdb_src, output, clog2(N_SRC): index of the source that won the broadcast.

Function
REQ-015 SHALL keep one FIFO of DEPTH {tag, data} entries per source, each with a read pointer, a write pointer and a count register.
REQ-016 SHALL drive src_ready[i] high exactly when count[i] < DEPTH; the value is taken from registered count only, so a full FIFO does not accept a push in the same cycle as a pop.
REQ-017 SHALL push into FIFO i when src_valid[i] and src_ready[i] are both high; when src_valid[i] is high and src_ready[i] is low, the source holds the result and nothing is written.
REQ-018 SHALL treat source i as requesting when count[i] is nonzero.
REQ-019 SHALL grant at most one requester per cycle, by round-robin starting at rr_ptr and scanning upward modulo N_SRC.
REQ-020 SHALL, on a grant to source g, pop FIFO g and advance rr_ptr to (g+1) mod N_SRC; with no grant, rr_ptr SHALL be held.
REQ-021 SHALL register the CDB outputs: the cycle after a grant, cdb_valid=1 and cdb_tag, cdb_data and cdb_src carry the popped entry.
REQ-022 SHALL drive cdb_valid=0 in any cycle following a no-grant cycle, with cdb_tag, cdb_data and cdb_src holding their last values.
REQ-023 SHALL give a minimum latency of 2 cycles from an accepted src_valid to cdb_valid: push at edge t, grant and pop at edge t+1, output visible after edge t+1.
REQ-024 SHALL perform simultaneous push and pop on the same non-full FIFO in one cycle, leaving count unchanged and preserving FIFO order.
REQ-025 SHALL wrap read and write pointers modulo DEPTH with no loss or duplication of entries.
REQ-026 SHALL preserve per-source order; ordering between different sources is not guaranteed.
REQ-027 SHALL, on flush, zero all counts and pointers and drive cdb_valid=0 on the next cycle, ignoring same-cycle pushes; rr_ptr is kept.
REQ-028 SHALL give a broadcast registered in the cycle flush is asserted no special handling; it completes normally.

Reset
REQ-029 SHALL, while rst is high, asynchronously force all counts, pointers and rr_ptr to 0 and cdb_valid, cdb_tag, cdb_data and cdb_src to 0.
REQ-030 SHALL drive src_ready to all ones during and after reset; FIFO storage contents need no reset.
REQ-031 SHALL drop any result buffered when rst is asserted mid-operation; it is never broadcast.

Verification
REQ-032 SHALL cover a single result: src_valid[2]=1, tag 0x15, data 0xDEADBEEF for one cycle -> two cycles later cdb_valid=1, cdb_tag=0x15, cdb_data=0xDEADBEEF, cdb_src=2 for exactly one cycle.
REQ-033 SHALL cover contention: all 4 sources push once in the same cycle with rr_ptr=0 -> cdb_src sequence 0,1,2,3 on 4 consecutive cycles, then cdb_valid=0.
REQ-034 SHALL cover backpressure: source 1 pushes 3 back-to-back results while sources 0, 2 and 3 each continuously refill with single results -> src_ready[1]=0 after 2 accepted, the held third is accepted later, and all 3 appear in push order.
REQ-035 SHALL cover fairness: sources 0 and 3 continuously valid -> broadcasts alternate 0,3,0,3, and neither source waits more than N_SRC cycles.
REQ-036 SHALL cover flush: 2 entries in source 0 plus a same-cycle push on source 1, then flush -> no further cdb_valid, and src_ready=4'b1111 next cycle.
REQ-037 SHALL cover reset mid-operation: rst asserted asynchronously between edges while entries are queued -> cdb_valid=0 immediately, and no stale broadcast after rst is released.
